// File: rtl/lpf_stream_ctrl.sv
// Sequencing controller between the sample source and the FIR low-pass engine:
// flushes filter history with zeros, pairs each accepted input with one filter
// output, offers a one-cycle registered bypass, and recovers a stuck filter.
module lpf_stream_ctrl #(
  parameter int unsigned W         = 32,
  parameter int unsigned FLUSH_LEN = 41,
  parameter int unsigned MAX_OUT   = 1,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic         f_x_valid,
  input  logic         f_x_ready,
  output logic [W-1:0] f_x_data,
  input  logic         f_y_valid,
  output logic         f_y_ready,
  input  logic [W-1:0] f_y_data,
  input  logic         cfg_bypass,
  input  logic         cfg_flush,
  input  logic         cfg_clear_err,
  output logic [1:0]   state,
  output logic         busy,
  output logic         err_timeout
);

  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
  localparam int unsigned FL_W  = $clog2(FLUSH_LEN + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_FLUSH  = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_BYPASS = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             tgt_byp_q, tgt_byp_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [FL_W-1:0]  flush_q, flush_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             err_q, err_d;
  logic             full_q, full_d;
  logic [W-1:0]     bdata_q, bdata_d;

  logic has_room, pending, fx_hs, fy_hs;

  assign state       = state_q;
  assign busy        = (state_q == ST_FLUSH) || (state_q == ST_DRAIN);
  assign err_timeout = err_q;

  // State registers; reset discards everything, including in-flight accounting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FLUSH;
      tgt_byp_q <= 1'b0;
      out_q     <= '0;
      flush_q   <= '0;
      wd_q      <= '0;
      err_q     <= 1'b0;
      full_q    <= 1'b0;
      bdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      tgt_byp_q <= tgt_byp_d;
      out_q     <= out_d;
      flush_q   <= flush_d;
      wd_q      <= wd_d;
      err_q     <= err_d;
      full_q    <= full_d;
      bdata_q   <= bdata_d;
    end
  end

  // Next-state, handshake steering, outstanding tracking and watchdog.
  always_comb begin
    state_d   = state_q;
    tgt_byp_d = tgt_byp_q;
    out_d     = out_q;
    flush_d   = flush_q;
    wd_d      = wd_q;
    err_d     = err_q;
    full_d    = full_q;
    bdata_d   = bdata_q;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    m_data    = '0;
    f_x_valid = 1'b0;
    f_x_data  = '0;
    f_y_ready = 1'b0;

    has_room = out_q < OUT_W'(MAX_OUT);
    pending  = out_q != '0;

    case (state_q)
      ST_FLUSH: begin
        f_x_valid = (flush_q < FL_W'(FLUSH_LEN)) && has_room;
        f_y_ready = pending;
        if ((flush_q == FL_W'(FLUSH_LEN)) && !pending) begin
          state_d = cfg_bypass ? ST_BYPASS : ST_RUN;
          flush_d = '0;
        end
      end
      ST_RUN: begin
        f_x_valid = s_valid && has_room;
        s_ready   = f_x_ready && has_room;
        f_x_data  = s_data;
        m_valid   = f_y_valid && pending;
        f_y_ready = m_ready && pending;
        m_data    = f_y_data;
        if (cfg_bypass) begin
          state_d   = ST_DRAIN;
          tgt_byp_d = 1'b1;
        end else if (cfg_flush) begin
          state_d   = ST_DRAIN;
          tgt_byp_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        m_valid   = f_y_valid && pending;
        f_y_ready = m_ready && pending;
        m_data    = f_y_data;
        if (!pending) state_d = tgt_byp_q ? ST_BYPASS : ST_FLUSH;
      end
      ST_BYPASS: begin
        m_valid = full_q;
        m_data  = bdata_q;
        if (cfg_bypass) begin
          s_ready = !full_q || m_ready;
        end else if (!full_q) begin
          state_d = ST_FLUSH;
        end
        if (m_valid && m_ready) full_d = 1'b0;
        if (s_valid && s_ready) begin
          full_d  = 1'b1;
          bdata_d = s_data;
        end
      end
      default: state_d = ST_FLUSH;
    endcase

    // The flush-zero request must not appear while reset is held.
    if (reset) f_x_valid = 1'b0;

    fx_hs = f_x_valid && f_x_ready;
    fy_hs = f_y_valid && f_y_ready;

    if (fx_hs && !fy_hs)      out_d = out_q + OUT_W'(1);
    else if (fy_hs && !fx_hs) out_d = out_q - OUT_W'(1);

    if ((state_q == ST_FLUSH) && fx_hs) flush_d = flush_q + FL_W'(1);

    if (cfg_clear_err) err_d = 1'b0;

    // Watchdog: a stuck filter drops its in-flight work and forces a fresh flush.
    if ((state_q != ST_BYPASS) && pending && !fy_hs) begin
      if (wd_q == WD_W'(TIMEOUT - 1)) begin
        wd_d    = '0;
        err_d   = 1'b1;
        out_d   = '0;
        flush_d = '0;
        state_d = ST_FLUSH;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end else begin
      wd_d = '0;
    end
  end

endmodule

// File: tb/tb_lpf_stream_ctrl.sv
// Scoreboard bench for lpf_stream_ctrl with an echo-plus-one filter model.
module tb_lpf_stream_ctrl;

  localparam int unsigned W  = 32;
  localparam int unsigned FL = 41;
  localparam int unsigned MO = 1;
  localparam int unsigned TO = 16;

  localparam int PH_OTHER = 0;
  localparam int PH_FLUSH = 1;
  localparam int PH_RUN   = 2;
  localparam int PH_BYP   = 3;

  logic         clk, reset;
  logic         s_valid, s_ready, m_valid, m_ready;
  logic [W-1:0] s_data, m_data;
  logic         f_x_valid, f_x_ready, f_y_valid, f_y_ready;
  logic [W-1:0] f_x_data, f_y_data;
  logic         cfg_bypass, cfg_flush, cfg_clear_err;
  logic [1:0]   state;
  logic         busy, err_timeout;

  lpf_stream_ctrl #(.W(W), .FLUSH_LEN(FL), .MAX_OUT(MO), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .f_x_valid(f_x_valid), .f_x_ready(f_x_ready), .f_x_data(f_x_data),
    .f_y_valid(f_y_valid), .f_y_ready(f_y_ready), .f_y_data(f_y_data),
    .cfg_bypass(cfg_bypass), .cfg_flush(cfg_flush), .cfg_clear_err(cfg_clear_err),
    .state(state), .busy(busy), .err_timeout(err_timeout)
  );

  typedef struct {
    logic [W-1:0] d;
    int           rdy;
  } fitem_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int phase, mdl_out, fx_cnt, mr_mode, lat_fix, mr_low_run;
  bit filt_hold, inject;
  logic [W-1:0] exp_q[$];
  fitem_t       fq[$];
  logic         fx, fy, sh, mh;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait budget expired (cycle %0d)", nm, cyc);
  endtask

  // Filter model and downstream sink drive their inputs just after each edge.
  always @(posedge clk) begin
    #1;
    f_x_ready = filt_hold ? 1'b0 : ($urandom_range(3) != 0);
    if (reset) begin
      f_y_valid = 1'b0;
      f_y_data  = '0;
    end else if (fq.size() > 0 && fq[0].rdy <= cyc) begin
      f_y_valid = 1'b1;
      f_y_data  = fq[0].d;
    end else if (inject) begin
      f_y_valid = 1'b1;
      f_y_data  = 32'hDEADBEEF;
    end else begin
      f_y_valid = 1'b0;
      f_y_data  = '0;
    end
    case (mr_mode)
      1: m_ready = 1'b0;
      2: m_ready = 1'b1;
      default: begin
        m_ready = (mr_low_run >= 3) ? 1'b1 : 1'($urandom_range(1));
        mr_low_run = m_ready ? 0 : mr_low_run + 1;
      end
    endcase
  end

  // Monitor: observes handshakes that complete at the coming edge.
  always @(negedge clk) begin
    if (!reset) begin
      fx = f_x_valid & f_x_ready;
      fy = f_y_valid & f_y_ready;
      sh = s_valid & s_ready;
      mh = m_valid & m_ready;
      if (mdl_out == 0) chk("fy_ready_idle", W'(f_y_ready), W'(0));
      case (phase)
        PH_FLUSH: begin
          chk("m_valid_flush", W'(m_valid), W'(0));
          if (fx) chk("flush_zero", f_x_data, W'(0));
        end
        PH_RUN: begin
          if (mdl_out >= int'(MO)) chk("s_ready_full", W'(s_ready), W'(0));
          else chk("s_ready_follow", W'(s_ready), W'(f_x_ready));
          if (sh) begin
            chk("run_fx_valid", W'(f_x_valid), W'(1));
            chk("run_fx_data", f_x_data, s_data);
          end
        end
        PH_BYP: begin
          chk("byp_fx_valid", W'(f_x_valid), W'(0));
          chk("byp_fy_ready", W'(f_y_ready), W'(0));
        end
        default: ;
      endcase
      if (sh) exp_q.push_back((phase == PH_BYP) ? s_data : W'(s_data + 32'd1));
      if (mh) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL m_unexpected: got %h expected no output (cycle %0d)", m_data, cyc);
        end else begin
          chk("m_data", m_data, exp_q.pop_front());
        end
      end
      if (fy) begin
        if (fq.size() > 0) void'(fq.pop_front());
        mdl_out--;
      end
      if (fx) begin
        fitem_t it;
        it.d   = W'(f_x_data + 32'd1);
        it.rdy = cyc + ((lat_fix != 0) ? lat_fix : int'($urandom_range(5, 1)));
        if (fq.size() > 0 && it.rdy < fq[$].rdy) it.rdy = fq[$].rdy;
        fq.push_back(it);
        fx_cnt++;
        mdl_out++;
      end
      chk("outstanding_bound", W'(mdl_out <= int'(MO)), W'(1));
    end
  end

  task automatic send(input logic [W-1:0] d);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("send");
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, input string nm);
    bit ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (state == st) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail(nm);
    @(posedge clk); #1;
  endtask

  task automatic wait_flush_done(input string nm);
    bit ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (state == 2'd1) begin
        ok = 1'b1;
        break;
      end
      chk("s_ready_in_flush", W'(s_ready), W'(0));
    end
    if (!ok) timeout_fail(nm);
    @(posedge clk); #1;
  endtask

  task automatic wait_empty(input string nm);
    bit ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail(nm);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0;
    cfg_bypass = 1'b0; cfg_flush = 1'b0; cfg_clear_err = 1'b0;
    f_x_ready = 1'b1; f_y_valid = 1'b0; f_y_data = '0; m_ready = 1'b1;
    mr_mode = 2; lat_fix = 12; filt_hold = 1'b0; inject = 1'b0; mr_low_run = 0;
    phase = PH_FLUSH; mdl_out = 0; fx_cnt = 0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", W'(state), W'(0));
    chk("rst_busy", W'(busy), W'(1));
    chk("rst_err", W'(err_timeout), W'(0));
    chk("rst_s_ready", W'(s_ready), W'(0));
    chk("rst_m_valid", W'(m_valid), W'(0));
    chk("rst_m_data", m_data, W'(0));
    chk("rst_fx_valid", W'(f_x_valid), W'(0));
    chk("rst_fx_data", f_x_data, W'(0));
    chk("rst_fy_ready", W'(f_y_ready), W'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("first_fx_valid", W'(f_x_valid), W'(1));
    chk("first_fx_data", f_x_data, W'(0));
    wait_flush_done("init_flush");
    chk("init_flush_count", W'(fx_cnt), W'(FL));
    chk("run_busy", W'(busy), W'(0));
    phase = PH_RUN;

    // Directed RUN with echo filter
    lat_fix = 3;
    send(32'h00010000);
    send(32'h00020000);
    send(32'h00030000);
    wait_empty("run_directed");

    // Filter output with nothing outstanding must be ignored
    inject = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("spurious_m_valid", W'(m_valid), W'(0));
    end
    @(posedge clk); #1;
    inject = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Randomized RUN traffic
    lat_fix = 0;
    mr_mode = 0;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(2)) begin @(posedge clk); #1; end
      send($urandom);
    end
    wait_empty("run_random");

    // Watchdog: result held by downstream for 20 cycles
    lat_fix = 1;
    mr_mode = 1;
    send(32'h00000A0A);
    filt_hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("wd_fy_ready", W'(f_y_ready), W'(0));
      if (i == 8) chk("wd_err_early", W'(err_timeout), W'(0));
    end
    chk("wd_err_set", W'(err_timeout), W'(1));
    chk("wd_state", W'(state), W'(0));
    chk("wd_busy", W'(busy), W'(1));
    @(posedge clk); #1;
    chk("wd_lost_sample", W'(exp_q.size()), W'(1));
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    fq.delete();
    mdl_out = 0; fx_cnt = 0; filt_hold = 1'b0; mr_mode = 0; lat_fix = 12;
    phase = PH_FLUSH;
    cfg_clear_err = 1'b1;
    @(negedge clk);
    chk("wd_outstanding_cleared", W'(f_x_valid), W'(1));
    @(posedge clk); #1;
    cfg_clear_err = 1'b0;
    @(negedge clk);
    chk("wd_err_cleared", W'(err_timeout), W'(0));
    wait_flush_done("wd_flush");
    chk("wd_flush_count", W'(fx_cnt), W'(FL));
    phase = PH_RUN;

    // Bypass entry with one sample outstanding
    lat_fix = 12;
    mr_mode = 2;
    send(32'h00000042);
    phase = PH_OTHER;
    cfg_bypass = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("drain_state", W'(state), W'(2));
    chk("drain_busy", W'(busy), W'(1));
    wait_state(2'd3, 100, "enter_bypass");
    chk("drain_delivered", W'(exp_q.size()), W'(0));
    phase = PH_BYP;
    s_valid = 1'b1;
    s_data  = 32'h12345678;
    @(negedge clk);
    chk("byp_accept", W'(s_ready), W'(1));
    chk("byp_not_comb", W'(m_valid), W'(0));
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("byp_m_valid", W'(m_valid), W'(1));
    chk("byp_m_data", m_data, 32'h12345678);
    @(posedge clk); #1;
    mr_mode = 0;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(1)) begin @(posedge clk); #1; end
      send($urandom);
    end
    wait_empty("byp_random");
    fx_cnt = 0;
    phase = PH_OTHER;
    cfg_bypass = 1'b0;
    wait_state(2'd0, 100, "leave_bypass");
    phase = PH_FLUSH;
    wait_flush_done("byp_flush");
    chk("byp_flush_count", W'(fx_cnt), W'(FL));
    phase = PH_RUN;

    // Flush pulse while idle, then reset mid-flush
    phase = PH_OTHER;
    cfg_flush = 1'b1;
    @(posedge clk); #1;
    cfg_flush = 1'b0;
    @(negedge clk);
    chk("fl_drain", W'(state), W'(2));
    @(negedge clk);
    chk("fl_flush", W'(state), W'(0));
    @(posedge clk); #1;
    phase = PH_FLUSH;
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_state", W'(state), W'(0));
    chk("midrst_fx_valid", W'(f_x_valid), W'(0));
    chk("midrst_busy", W'(busy), W'(1));
    fq.delete();
    mdl_out = 0;
    fx_cnt  = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_restart", W'(f_x_valid), W'(1));
    wait_flush_done("midrst_flush");
    chk("midrst_flush_count", W'(fx_cnt), W'(FL));
    phase = PH_RUN;

    // Closing RUN traffic after all recoveries
    lat_fix = 0;
    for (int i = 0; i < 10; i++) send($urandom);
    wait_empty("final_drain");
    chk("final_queue_empty", W'(exp_q.size()), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
